// File: rtl/matvec_stream_sequencer.sv
// Byte-stream loader and result serialiser for the NxN matrix-vector array.
// Optional MATVEC_REUSE_A_EN: keep the loaded matrix and stream only vectors on later frames.
module matvec_stream_sequencer #(
  parameter int N      = 16,
  parameter int DW     = 8,
  parameter int SETTLE = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  output logic signed [DW-1:0] A_o [0:N-1][0:N-1],
  output logic signed [DW-1:0] B_o [0:N-1],
  input  logic signed [DW-1:0] C_i [0:N-1],
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [DW-1:0] m_data,
  output logic                 m_last,
  output logic                 busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(SETTLE);

  typedef enum logic [2:0] {
    ST_LOAD_A,
    ST_LOAD_B,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

  state_t              state_reg, state_next;
  logic [IW-1:0]       row_reg, col_reg, bidx_reg, drain_reg;
  logic [SW-1:0]       settle_reg;
  logic                s_ready_reg, busy_reg;
  logic signed [DW-1:0] res_buf [0:N-1];
  logic                s_fire, m_fire, load_a, load_b;
  logic                a_last, b_last, d_last;

  assign s_fire = s_valid && s_ready_reg;
  assign m_fire = m_valid && m_ready;
  assign load_a = s_fire && (state_reg == ST_LOAD_A);
  assign load_b = s_fire && (state_reg == ST_LOAD_B);
  assign a_last = (row_reg == IW'(N-1)) && (col_reg == IW'(N-1));
  assign b_last = (bidx_reg == IW'(N-1));
  assign d_last = (drain_reg == IW'(N-1));

`ifdef MATVEC_REUSE_A_EN
  // Set once a full matrix has landed; lets DRAIN skip straight to the vector load.
  logic a_valid_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      a_valid_reg <= 1'b0;
    else if (load_a && a_last)
      a_valid_reg <= 1'b1;
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LOAD_A:  if (s_fire && a_last) state_next = ST_LOAD_B;
      ST_LOAD_B:  if (s_fire && b_last) state_next = ST_SETTLE;
      ST_SETTLE:  if (settle_reg == SW'(SETTLE-2)) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (m_fire && d_last) begin
`ifdef MATVEC_REUSE_A_EN
          state_next = a_valid_reg ? ST_LOAD_B : ST_LOAD_A;
`else
          state_next = ST_LOAD_A;
`endif
        end
      end
      default:    state_next = ST_LOAD_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_LOAD_A;
      row_reg     <= '0;
      col_reg     <= '0;
      bidx_reg    <= '0;
      drain_reg   <= '0;
      settle_reg  <= '0;
      s_ready_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      // s_ready is registered from the next state, so it drops in the cycle after the last B.
      s_ready_reg <= (state_next == ST_LOAD_A) || (state_next == ST_LOAD_B);

      if (load_a) begin
        if (col_reg == IW'(N-1)) begin
          col_reg <= '0;
          row_reg <= (row_reg == IW'(N-1)) ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end

      if (load_b)
        bidx_reg <= b_last ? '0 : bidx_reg + 1'b1;

      if (state_reg == ST_SETTLE)
        settle_reg <= settle_reg + 1'b1;
      else
        settle_reg <= '0;

      if (m_fire)
        drain_reg <= d_last ? '0 : drain_reg + 1'b1;

      if (s_fire)
        busy_reg <= 1'b1;
      else if (m_fire && d_last)
        busy_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          A_o[i][j] <= '0;
    end else if (load_a) begin
      A_o[row_reg][col_reg] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < N; j++)
        B_o[j] <= '0;
    end else if (load_b) begin
      B_o[bidx_reg] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < N; j++)
        res_buf[j] <= '0;
    end else if (state_reg == ST_CAPTURE) begin
      for (int j = 0; j < N; j++)
        res_buf[j] <= C_i[j];
    end
  end

  assign s_ready = s_ready_reg;
  assign busy    = busy_reg;
  assign m_valid = (state_reg == ST_DRAIN);
  assign m_data  = m_valid ? res_buf[drain_reg] : '0;
  assign m_last  = m_valid && d_last;

endmodule
